// File: rtl/jtag_arb_pkg.sv
// Shared types and constants for the two-master JTAG pin arbiter.
package jtag_arb_pkg;

  typedef enum logic [1:0] {IDLE, RESET_TAP, GRANT, PARK} arb_state_t;
  typedef logic owner_t;

  localparam logic PARK_TCK = 1'b0;
  localparam logic PARK_TMS = 1'b1;
  localparam logic PARK_TDI = 1'b1;

  // Counter width that never collapses to zero bits for tiny parameters.
  function automatic int cw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // A tie goes to the master that did not own the pins last.
  function automatic owner_t pick_owner(input logic [1:0] req, input owner_t last);
    if (&req) return ~last;
    return req[1];
  endfunction

  function automatic logic [1:0] onehot(input owner_t o);
    return o ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/jtag_port_arbiter_if.sv
// Master-side request/grant and pin signals of the JTAG port arbiter.
interface jtag_port_arbiter_if;
  logic [1:0] i_req;
  logic [1:0] o_gnt;
  logic [1:0] o_revoke;
  logic       i_tck0, i_tdi0, i_tms0;
  logic       i_tck1, i_tdi1, i_tms1;
  logic       o_tdo0, o_tdo1;
  logic       o_tck, o_tdi, o_tms;
  logic       i_tdo;
  logic       o_busy;

  modport slave (
    input  i_req, i_tck0, i_tdi0, i_tms0, i_tck1, i_tdi1, i_tms1, i_tdo,
    output o_gnt, o_revoke, o_tdo0, o_tdo1, o_tck, o_tdi, o_tms, o_busy
  );

  modport master (
    output i_req, i_tck0, i_tdi0, i_tms0, i_tck1, i_tdi1, i_tms1, i_tdo,
    input  o_gnt, o_revoke, o_tdo0, o_tdo1, o_tck, o_tdi, o_tms, o_busy
  );
endinterface

// File: rtl/jtag_tlr_sequencer.sv
// Generates the Test-Logic-Reset burst: TLR_CYCLES TCK periods with TMS=1,
// starting low and ending with one extra low half-period.
module jtag_tlr_sequencer
  import jtag_arb_pkg::*;
#(
  parameter int TCK_HALF   = 25,
  parameter int TLR_CYCLES = 5
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic start_i,
  output logic done_o,
  output logic tck_o,
  output logic tms_o,
  output logic tdi_o
);

  localparam int HW = cw(TCK_HALF);
  localparam int EW = cw(TLR_CYCLES + 1);
  localparam logic [HW-1:0] HALF_LAST = HW'(TCK_HALF - 1);
  localparam logic [EW-1:0] EDGES     = EW'(TLR_CYCLES);

  logic          active_q;
  logic [HW-1:0] hcnt_q;
  logic [EW-1:0] ecnt_q;
  logic          tck_q;
  logic          done_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      active_q <= 1'b0;
      hcnt_q   <= '0;
      ecnt_q   <= '0;
      tck_q    <= PARK_TCK;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (start_i) begin
        active_q <= 1'b1;
        hcnt_q   <= '0;
        ecnt_q   <= '0;
        tck_q    <= 1'b0;
      end else if (active_q) begin
        if (hcnt_q == HALF_LAST) begin
          hcnt_q <= '0;
          if (tck_q) begin
            tck_q <= 1'b0;
          end else if (ecnt_q == EDGES) begin
            // Final low half finished after the last rising edge.
            active_q <= 1'b0;
            done_q   <= 1'b1;
          end else begin
            tck_q  <= 1'b1;
            ecnt_q <= ecnt_q + 1'b1;
          end
        end else begin
          hcnt_q <= hcnt_q + 1'b1;
        end
      end
    end
  end

  assign done_o = done_q;
  assign tck_o  = tck_q;
  assign tms_o  = PARK_TMS;
  assign tdi_o  = PARK_TDI;

endmodule

// File: rtl/jtag_port_arbiter.sv
// Round-robin owner of the external JTAG pins for two masters, with a TAP
// reset burst before every grant and idle-owner revocation.
module jtag_port_arbiter
  import jtag_arb_pkg::*;
#(
  parameter int TCK_HALF     = 25,
  parameter int TLR_CYCLES   = 5,
  parameter int IDLE_TIMEOUT = 50000
) (
  input logic               i_clk,
  input logic               i_reset_n,
  jtag_port_arbiter_if.slave bus
);

  localparam int TW = cw(IDLE_TIMEOUT + 1);
  localparam logic [TW-1:0] TO_MAX = TW'(IDLE_TIMEOUT);

  arb_state_t    state_q;
  owner_t        tgt_q, last_q;
  logic [1:0]    gnt_q, rev_q;
  logic          busy_q;
  logic          tck_q, tms_q, tdi_q;
  logic [TW-1:0] to_q;
  logic          tckp_q;

  logic seq_start, seq_done, seq_tck, seq_tms, seq_tdi;
  logic own_req, oth_req, own_tck, own_tms, own_tdi, timeout_hit;

  assign seq_start = (state_q == IDLE) && (|bus.i_req);
  assign own_req   = bus.i_req[tgt_q];
  assign oth_req   = bus.i_req[~tgt_q];
  assign own_tck   = tgt_q ? bus.i_tck1 : bus.i_tck0;
  assign own_tms   = tgt_q ? bus.i_tms1 : bus.i_tms0;
  assign own_tdi   = tgt_q ? bus.i_tdi1 : bus.i_tdi0;
  assign timeout_hit = (IDLE_TIMEOUT != 0) && (to_q == TO_MAX) && oth_req;

  jtag_tlr_sequencer #(.TCK_HALF(TCK_HALF), .TLR_CYCLES(TLR_CYCLES)) u_tlr (
    .clk_i   (i_clk),
    .rst_ni  (i_reset_n),
    .start_i (seq_start),
    .done_o  (seq_done),
    .tck_o   (seq_tck),
    .tms_o   (seq_tms),
    .tdi_o   (seq_tdi)
  );

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q <= IDLE;
      tgt_q   <= 1'b0;
      last_q  <= 1'b1;
      gnt_q   <= '0;
      rev_q   <= '0;
      busy_q  <= 1'b0;
      tck_q   <= PARK_TCK;
      tms_q   <= PARK_TMS;
      tdi_q   <= PARK_TDI;
      to_q    <= '0;
      tckp_q  <= 1'b0;
    end else begin
      rev_q <= '0;
      unique case (state_q)
        IDLE: begin
          tck_q <= PARK_TCK;
          tms_q <= PARK_TMS;
          tdi_q <= PARK_TDI;
          if (|bus.i_req) begin
            tgt_q   <= pick_owner(bus.i_req, last_q);
            state_q <= RESET_TAP;
            busy_q  <= 1'b1;
          end
        end
        RESET_TAP: begin
          tck_q <= seq_tck;
          tms_q <= seq_tms;
          tdi_q <= seq_tdi;
          if (seq_done) begin
            if (own_req) begin
              state_q <= GRANT;
              gnt_q   <= onehot(tgt_q);
              last_q  <= tgt_q;
              to_q    <= '0;
              tckp_q  <= own_tck;
            end else begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end
          end
        end
        GRANT: begin
          tck_q  <= own_tck;
          tms_q  <= own_tms;
          tdi_q  <= own_tdi;
          tckp_q <= own_tck;
          // Release wins over a coincident timeout: no revoke pulse then.
          if (!own_req || timeout_hit) begin
            state_q <= PARK;
            gnt_q   <= '0;
            tck_q   <= PARK_TCK;
            tms_q   <= PARK_TMS;
            tdi_q   <= PARK_TDI;
            if (own_req) rev_q[tgt_q] <= 1'b1;
          end else if (own_tck != tckp_q) begin
            to_q <= '0;
          end else if (to_q != TO_MAX) begin
            to_q <= to_q + 1'b1;
          end
        end
        PARK: begin
          tck_q   <= PARK_TCK;
          tms_q   <= PARK_TMS;
          tdi_q   <= PARK_TDI;
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          gnt_q   <= '0;
        end
      endcase
    end
  end

  assign bus.o_gnt    = gnt_q;
  assign bus.o_revoke = rev_q;
  assign bus.o_busy   = busy_q;
  assign bus.o_tck    = tck_q;
  assign bus.o_tms    = tms_q;
  assign bus.o_tdi    = tdi_q;
  assign bus.o_tdo0   = gnt_q[0] ? bus.i_tdo : 1'b1;
  assign bus.o_tdo1   = gnt_q[1] ? bus.i_tdo : 1'b1;

endmodule

// File: tb/tb_jtag_port_arbiter.sv
// Bench for jtag_port_arbiter: grant scoreboard, TDO routing table and
// hand-written sequences for burst, handoff, timeout and reset corners.
module tb_jtag_port_arbiter;

  localparam int TCK_HALF     = 25;
  localparam int TLR_CYCLES   = 5;
  localparam int IDLE_TIMEOUT = 100;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #10 clk = ~clk;

  jtag_port_arbiter_if bus ();

  jtag_port_arbiter #(
    .TCK_HALF(TCK_HALF), .TLR_CYCLES(TLR_CYCLES), .IDLE_TIMEOUT(IDLE_TIMEOUT)
  ) dut (
    .i_clk     (clk),
    .i_reset_n (rst_n),
    .bus       (bus)
  );

  int errors = 0;
  int checks = 0;
  logic [1:0] exp_q[$];
  int rev_cnt = 0;
  logic onehot_bad = 1'b0;
  logic [1:0] gnt_prev = 2'b00;

  typedef struct {
    logic [1:0] gnt;
    logic       tdo;
    logic       e0;
    logic       e1;
  } tdo_vec_t;
  tdo_vec_t tv[6];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Grant scoreboard: every new grant must match the oldest expectation.
  initial begin
    logic [1:0] e;
    forever begin
      @(negedge clk);
      if (bus.o_gnt == 2'b11) onehot_bad = 1'b1;
      if (bus.o_revoke != 2'b00) rev_cnt++;
      if (bus.o_gnt != 2'b00 && gnt_prev == 2'b00) begin
        if (exp_q.size() == 0) chk("unexpected_grant", int'(bus.o_gnt), 0);
        else begin
          e = exp_q.pop_front();
          chk("grant_order", int'(bus.o_gnt), int'(e));
        end
      end
      gnt_prev = bus.o_gnt;
    end
  end

  task automatic run_tdo(input logic [1:0] g);
    for (int i = 0; i < 6; i++) begin
      if (tv[i].gnt == g) begin
        bus.i_tdo = tv[i].tdo;
        #1;
        chk($sformatf("tdo0_g%0d_t%0d", g, tv[i].tdo), int'(bus.o_tdo0), int'(tv[i].e0));
        chk($sformatf("tdo1_g%0d_t%0d", g, tv[i].tdo), int'(bus.o_tdo1), int'(tv[i].e1));
      end
    end
    bus.i_tdo = 1'b1;
  endtask

  task automatic burst_watch(input int drop_at, output int rises, output int bad_per,
                             output int bad_pin);
    int n, last;
    logic pt;
    n = 0; last = 0; rises = 0; bad_per = 0; bad_pin = 0;
    pt = bus.o_tck;
    while (bus.o_gnt == 2'b00 && bus.o_busy && n < 700) begin
      if (bus.o_tms !== 1'b1 || bus.o_tdi !== 1'b1) bad_pin++;
      if (bus.o_tck && !pt) begin
        if (rises > 0 && (n - last) != 2 * TCK_HALF) bad_per++;
        rises++;
        last = n;
      end
      pt = bus.o_tck;
      @(negedge clk);
      n++;
      if (n == drop_at) bus.i_req = 2'b00;
    end
  endtask

  task automatic wait_gnt(input logic [1:0] g, input string name);
    int n;
    n = 0;
    while (bus.o_gnt !== g && n < 700) begin
      @(negedge clk);
      n++;
    end
    chk(name, int'(bus.o_gnt), int'(g));
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (bus.o_busy !== 1'b0 && n < 700) begin
      @(negedge clk);
      n++;
    end
    chk(name, int'(bus.o_busy), 0);
  endtask

  initial begin
    int r, bp, bpin, r0, n;
    tv[0] = '{2'b00, 1'b0, 1'b1, 1'b1};
    tv[1] = '{2'b00, 1'b1, 1'b1, 1'b1};
    tv[2] = '{2'b01, 1'b0, 1'b0, 1'b1};
    tv[3] = '{2'b01, 1'b1, 1'b1, 1'b1};
    tv[4] = '{2'b10, 1'b0, 1'b1, 1'b0};
    tv[5] = '{2'b10, 1'b1, 1'b1, 1'b1};
    bus.i_req = 2'b00;
    bus.i_tck0 = 1'b0; bus.i_tms0 = 1'b0; bus.i_tdi0 = 1'b0;
    bus.i_tck1 = 1'b0; bus.i_tms1 = 1'b0; bus.i_tdi1 = 1'b0;
    bus.i_tdo = 1'b1;

    // Reset values
    repeat (3) @(negedge clk);
    chk("rst_tck", int'(bus.o_tck), 0);
    chk("rst_tms", int'(bus.o_tms), 1);
    chk("rst_tdi", int'(bus.o_tdi), 1);
    chk("rst_gnt", int'(bus.o_gnt), 0);
    chk("rst_revoke", int'(bus.o_revoke), 0);
    chk("rst_busy", int'(bus.o_busy), 0);
    run_tdo(2'b00);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_busy", int'(bus.o_busy), 0);

    // First tie after reset goes to master 0
    exp_q.push_back(2'b01);
    bus.i_req = 2'b11;
    @(negedge clk);
    chk("tie_busy", int'(bus.o_busy), 1);
    burst_watch(-1, r, bp, bpin);
    chk("tie_burst_rises", r, TLR_CYCLES);
    chk("tie_burst_period", bp, 0);
    chk("tie_burst_pins", bpin, 0);
    wait_gnt(2'b01, "tie_gnt0");
    run_tdo(2'b01);
    bus.i_tck0 = 1'b1; bus.i_tms0 = 1'b0;
    chk("tck_before_follow", int'(bus.o_tck), 0);
    @(negedge clk);
    chk("tck_follow_hi", int'(bus.o_tck), 1);
    chk("tms_follow_lo", int'(bus.o_tms), 0);
    bus.i_tck0 = 1'b0; bus.i_tms0 = 1'b1;
    @(negedge clk);
    chk("tck_follow_lo", int'(bus.o_tck), 0);

    // Handoff: PARK for one clock, IDLE for one, then burst to master 1
    exp_q.push_back(2'b10);
    bus.i_req = 2'b10;
    @(negedge clk);
    chk("park_gnt", int'(bus.o_gnt), 0);
    chk("park_busy", int'(bus.o_busy), 1);
    chk("park_tck", int'(bus.o_tck), 0);
    @(negedge clk);
    chk("park_idle", int'(bus.o_busy), 0);
    @(negedge clk);
    chk("handoff_busy", int'(bus.o_busy), 1);
    burst_watch(-1, r, bp, bpin);
    chk("handoff_burst_rises", r, TLR_CYCLES);
    wait_gnt(2'b10, "handoff_gnt1");
    run_tdo(2'b10);
    bus.i_req = 2'b00;
    wait_idle("idle_after_gnt1");

    // Master 0 alone, master 1 joins mid-burst, then master 0 idles out
    exp_q.push_back(2'b01);
    bus.i_req = 2'b01;
    @(negedge clk);
    chk("single_busy", int'(bus.o_busy), 1);
    bus.i_req = 2'b11;
    burst_watch(-1, r, bp, bpin);
    chk("single_burst_rises", r, TLR_CYCLES);
    chk("single_burst_period", bp, 0);
    wait_gnt(2'b01, "single_gnt0");
    n = 0;
    while (bus.o_revoke == 2'b00 && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("revoke_delay", n, IDLE_TIMEOUT + 1);
    chk("revoke_vec", int'(bus.o_revoke), 1);
    chk("revoke_gnt_clear", int'(bus.o_gnt), 0);
    exp_q.push_back(2'b10);
    bus.i_req = 2'b10;
    @(negedge clk);
    chk("revoke_width", int'(bus.o_revoke), 0);
    wait_gnt(2'b10, "after_revoke_gnt1");

    // Active owner keeps the pins even though the other master waits
    bus.i_req = 2'b11;
    r0 = rev_cnt;
    for (int k = 0; k < 300; k++) begin
      if (k % 50 == 0) bus.i_tck1 = ~bus.i_tck1;
      @(negedge clk);
    end
    chk("active_no_revoke", rev_cnt - r0, 0);
    chk("active_keeps_gnt", int'(bus.o_gnt), 2);

    // Release in the very cycle the timeout is reached: no revoke
    exp_q.push_back(2'b01);
    bus.i_req = 2'b01;
    wait_gnt(2'b01, "regrant0");
    bus.i_req = 2'b11;
    r0 = rev_cnt;
    repeat (IDLE_TIMEOUT) @(negedge clk);
    exp_q.push_back(2'b10);
    bus.i_req = 2'b10;
    @(negedge clk);
    chk("release_at_to_gnt", int'(bus.o_gnt), 0);
    chk("release_at_to_revoke", int'(bus.o_revoke), 0);
    wait_gnt(2'b10, "release_at_to_gnt1");
    chk("release_at_to_no_pulse", rev_cnt - r0, 0);
    bus.i_req = 2'b00;
    wait_idle("idle_after_release");

    // Request dropped mid-burst: burst completes, no grant
    bus.i_req = 2'b01;
    @(negedge clk);
    chk("midburst_busy", int'(bus.o_busy), 1);
    burst_watch(100, r, bp, bpin);
    chk("midburst_rises", r, TLR_CYCLES);
    chk("midburst_idle", int'(bus.o_busy), 0);
    repeat (5) @(negedge clk);
    chk("midburst_no_gnt", int'(bus.o_gnt), 0);

    // Asynchronous reset during a grant with TCK high
    exp_q.push_back(2'b01);
    bus.i_req = 2'b01;
    wait_gnt(2'b01, "prereset_gnt0");
    bus.i_tck0 = 1'b1;
    repeat (2) @(negedge clk);
    chk("prereset_tck", int'(bus.o_tck), 1);
    bus.i_tdo = 1'b0;
    #1;
    chk("prereset_tdo0", int'(bus.o_tdo0), 0);
    chk("prereset_tdo1", int'(bus.o_tdo1), 1);
    #4 rst_n = 1'b0;
    #1;
    chk("async_tck", int'(bus.o_tck), 0);
    chk("async_tms", int'(bus.o_tms), 1);
    chk("async_gnt", int'(bus.o_gnt), 0);
    chk("async_busy", int'(bus.o_busy), 0);
    chk("async_tdo0", int'(bus.o_tdo0), 1);
    chk("async_tdo1", int'(bus.o_tdo1), 1);
    bus.i_req = 2'b00; bus.i_tck0 = 1'b0; bus.i_tdo = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    chk("gnt_onehot", int'(onehot_bad), 0);
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/jtag_port_arbiter.md
Name: jtag_port_arbiter

Overview:
- Shares the board's single external JTAG pin set (TCK/TDI/TMS/TDO) between two masters.
- Requester 0 is the USB-blaster handler; requester 1 is an on-chip scan engine.
- Grants ownership one master at a time and forces the target TAP into Test-Logic-Reset before every handoff.
- Revokes an idle owner when the other master is waiting.
- Sits between the masters and the top-level JTAG pins, in the 50 MHz domain.

Parameters:
- TCK_HALF, 25: system clocks per TCK half-period during the arbiter's own TAP-reset burst (1 MHz at 50 MHz).
- TLR_CYCLES, 5: full TCK periods with TMS=1 in the reset burst.
- IDLE_TIMEOUT, 50000: owner-idle clocks before revocation when the other master waits; 0 disables revocation.

Ports:
- i_clk  in  1  system clock.
- i_reset_n  in  1  asynchronous active-low reset.
- i_req  in  2  request per master, level; held high for the whole ownership.
- o_gnt  out  2  one-hot grant; never both set.
- o_revoke  out  2  one-cycle pulse to the master whose grant was removed by timeout.
- i_tck0, i_tdi0, i_tms0  in  1 each  pin drive from master 0.
- i_tck1, i_tdi1, i_tms1  in  1 each  pin drive from master 1.
- o_tdo0, o_tdo1  out  1 each  TDO returned to each master.
- o_tck, o_tdi, o_tms  out  1 each  external JTAG pins, registered.
- i_tdo  in  1  external TDO.
- o_busy  out  1  high in any state other than IDLE.

Behaviour:
- Clock and reset: one clock, i_clk; reset i_reset_n is asynchronous, active-low.
- Reset values: o_tck=0, o_tms=1, o_tdi=1, o_gnt=0, o_revoke=0, o_busy=0, state=IDLE, last_owner=1. Asserting reset mid-operation forces these values immediately; there is no graceful release.
- Pin outputs are registered. In GRANTn, pins follow master n's inputs with 1-cycle latency.
- TDO routing: o_tdoN = i_tdo (combinational) while o_gnt[N]=1, else 1.
- State IDLE:
  - Pins parked (tck=0, tms=1, tdi=1).
  - Any request → RESET_TAP with target latched.
  - Both requests high → the master other than last_owner wins (round robin). First tie after reset goes to master 0.
- State RESET_TAP:
  - tms=1, tdi=1; o_tck toggles every TCK_HALF clocks, starting low.
  - Exits after TLR_CYCLES rising edges plus a final low half.
  - If the target's request is still high → GRANTn: o_gnt[n]=1, last_owner=n, timeout counter cleared.
  - Otherwise → IDLE.
  - A request dropping mid-burst does not abort the burst.
- State GRANTn:
  - Owner's request drops → PARK.
  - Timeout counter counts clocks since the last change of i_tcknN; any change clears it; it saturates at IDLE_TIMEOUT.
  - Counter == IDLE_TIMEOUT, other request high, and IDLE_TIMEOUT≠0 → pulse o_revoke[n] for one cycle, then PARK.
  - Request drop and timeout in the same cycle → treated as release; no revoke pulse.
- State PARK:
  - o_gnt cleared on entry; pins driven to park values for 1 clock; → IDLE.
  - Requests are re-evaluated only in IDLE, so minimum grant-to-grant gap is 2 clocks plus the burst.
- A revoked master must drop its request for ≥1 clock before re-requesting. If it keeps its request high, it is treated as a new request and competes in round robin.
- Counter widths:
  - Half-period counter: $clog2(TCK_HALF).
  - Edge counter: $clog2(TLR_CYCLES+1).
  - Timeout counter: $clog2(IDLE_TIMEOUT+1).
- Invariant: o_gnt is one-hot or zero in every cycle.

Decomposition:
- Package jtag_arb_pkg:
  - arb_state_t enum {IDLE, RESET_TAP, GRANT, PARK}.
  - owner_t (1-bit).
  - Park constants PARK_TCK=0, PARK_TMS=1, PARK_TDI=1.
- Sub-module jtag_tlr_sequencer:
  - Ports: start pulse in, done pulse out; drives tck/tms/tdi during the burst.
  - Parameterised by TCK_HALF and TLR_CYCLES.
- The arbiter FSM, timeout counter and pin mux live in the top module.

Test Plan:
- Reset, then i_req=01 → o_busy next clock; o_tck shows 5 rising edges of 50-clock period with o_tms=1; then o_gnt=01 and o_tck follows i_tck0 one clock later.
- i_req=11 simultaneously after reset → master 0 granted first. Drop req0 → PARK 1 clock, IDLE, burst, then o_gnt=10.
- Master 0 owns, i_tck0 static, req1 high, IDLE_TIMEOUT=100 → o_revoke=01 for exactly 1 clock after 100 idle clocks, then o_gnt=00, burst, o_gnt=10. Toggling i_tck0 every 50 clocks → no revoke.
- req0 dropped in the exact cycle the timeout is reached → no o_revoke pulse; normal PARK.
- req0 dropped mid-burst → burst completes (5 edges), returns to IDLE, o_gnt stays 00.
- i_reset_n asserted during GRANT0 with i_tck0=1 → o_tck=0, o_tms=1, o_gnt=00 asynchronously before the next clock edge. o_tdo0=o_tdo1=1 whenever not granted; i_tdo=0 appears only on the owner's TDO.
